capture_bank_scheduler: RTL and testbench
=========================================

Name: capture_bank_scheduler

Overview:
- Ping-pong controller between the PEM-synchronous capture stage and the phase-search engine.
- Routes per-period capture writes into one of two 512-word RAM banks.
- On each successful capture, hands the filled bank to the search engine and re-arms capture with a refresh_align pulse.
- Holds capture off while both banks are occupied.

Parameters:
- ADDR_W, 9, RAM address width per bank.
- DAT_W, 16, sample width.
- OVF_W, 16, width of the dropped-write counter.
- HOLDOFF, 4, cycles from bank swap to refresh_align pulse (range 1..15).
- TIMEOUT_CYCLES, 1000000, search watchdog limit (used only with the optional feature).

Ports:
- alg_clk  in  1  algorithm clock
- alg_rst_n  in  1  asynchronous active-low reset
- cap_ram_dat  in  DAT_W  capture write data
- cap_ram_addr  in  ADDR_W  capture write address
- cap_ram_wr_valid  in  1  capture write strobe
- cap_done  in  1  one-cycle pulse: capture succeeded (trig_search_cdc)
- refresh_align  out  1  one-cycle pulse: capture may start the next frame
- bank_we  out  2  per-bank write enable (bit0 = bank0)
- bank_waddr  out  ADDR_W  registered write address
- bank_wdat  out  DAT_W  registered write data
- search_start  out  1  one-cycle pulse: frame ready in search_bank
- search_bank  out  1  bank index owned by the search engine
- frame_len  out  ADDR_W+1  word count of the frame handed over (max addr + 1)
- search_done  in  1  one-cycle pulse: search engine released its bank
- ovf_cnt  out  OVF_W  saturating count of dropped writes
- busy  out  1  search engine currently owns a bank

Behaviour:
- Reset values:
  - all outputs 0; wr_bank = 0; state = FILL.
  - Clock is alg_clk; reset alg_rst_n is asynchronous, active-low.
- Write path: 1-cycle latency.
  - bank_we[wr_bank] = cap_ram_wr_valid delayed one cycle; the other bit is 0.
  - bank_waddr and bank_wdat are registered copies of the inputs.
  - In HOLD, writes are dropped: bank_we = 0 and ovf_cnt increments, saturating at all-ones.
- Frame length: max_addr tracks the largest cap_ram_addr written this frame; it clears on swap.
- States:
  - FILL: writing wr_bank.
    - cap_done with busy = 0 -> SWAP.
    - cap_done with busy = 1 -> HOLD.
  - HOLD: write bank full, search busy; refresh_align is withheld.
    - search_done -> SWAP.
  - SWAP (1 cycle):
    - search_bank <= wr_bank; wr_bank <= ~wr_bank.
    - frame_len <= max_addr + 1; busy <= 1; search_start pulses on exit.
    - Loads the holdoff counter with HOLDOFF -> ARM.
  - ARM: counter decrements.
    - At 0: refresh_align pulses for 1 cycle -> FILL.
    - Writes arriving in ARM go to the new wr_bank.
- search_done clears busy, in any state.
- Simultaneous events:
  - cap_done and search_done in the same cycle in FILL: treat as not busy -> SWAP.
  - cap_done in SWAP or ARM: ignored; it is a protocol violation, counted once into ovf_cnt.
  - search_done while busy = 0: ignored.
- Startup: capture free-runs its first frame without refresh_align, so FILL is entered directly from reset.
- Reset mid-operation: all state returns immediately to the reset values. In-flight pulses are lost; no partial bank handover occurs.

Optional Feature:
- Macro: CAPTURE_BANK_SEARCH_TIMEOUT_EN.
- Defined:
  - A 20-bit watchdog counts while busy = 1.
  - Reaching TIMEOUT_CYCLES forces busy <= 0 as if search_done had arrived, and sets a sticky output search_timeout (1 bit, cleared only by reset).
  - HOLD then proceeds to SWAP.
- Undefined:
  - No watchdog; the search_timeout port is absent.
  - busy clears only on search_done.

Decomposition:
- Package capture_bank_pkg holds:
  - the state enum (FILL, HOLD, SWAP, ARM);
  - ADDR_W, DAT_W defaults;
  - the bank index type.
- One sub-module: capture_bank_wr_mux. It contains the registered write path, the bank_we decode, the max_addr tracker, and the ovf_cnt saturation. The FSM stays in the top level.

Test Plan:
- Write addr 0..99 then cap_done with busy = 0:
  - writes land on bank_we = 2'b01, one cycle late;
  - search_bank = 0, frame_len = 100;
  - search_start 1 cycle after SWAP, refresh_align HOLDOFF cycles later;
  - wr_bank = 1.
- Second frame (addr 0..119) with cap_done and no search_done:
  - state HOLD, no refresh_align;
  - 5 further writes -> ovf_cnt = 5, bank_we = 0.
- Then search_done:
  - SWAP: search_bank = 1, frame_len = 120, refresh_align follows.
- cap_done and search_done in the same cycle during FILL:
  - immediate SWAP, no HOLD entry.
- Assert alg_rst_n low during ARM:
  - all outputs 0 asynchronously; no refresh_align after release; wr_bank = 0.
- With CAPTURE_BANK_SEARCH_TIMEOUT_EN and TIMEOUT_CYCLES = 50, holding search_done low:
  - busy clears after 50 cycles; search_timeout = 1; HOLD proceeds to SWAP.

Source files
------------

// File: rtl/capture_bank_pkg.sv
// Shared types and defaults for the capture bank ping-pong scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package capture_bank_pkg;

  localparam int CB_ADDR_W = 9;
  localparam int CB_DAT_W  = 16;

  // Index of one of the two capture RAM banks.
  typedef logic bank_idx_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    SWAP = 2'd2,
    ARM  = 2'd3
  } cb_state_t;

endpackage

// File: rtl/capture_bank_wr_mux.sv
// Registered capture write path: bank write-enable decode, frame max-address tracker, dropped-write counter.
// Latency: 1 cycle from wr_vld to bank_we / bank_waddr / bank_wdat.
// Backpressure: none; writes seen while drop is high are discarded and counted in ovf_cnt (saturating).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_dat/wr_addr/wr_vld capture write request
//   wr_bank               bank currently being filled
//   drop                  discard this cycle's write (counted)
//   viol                  protocol violation event (counted)
//   clr_max               restart max-address tracking for a new frame
//   bank_we/waddr/wdat    registered RAM write port
//   max_addr              largest address accepted this frame
//   ovf_cnt               saturating count of drops + violations
module capture_bank_wr_mux
  import capture_bank_pkg::*;
#(
  parameter int ADDR_W = CB_ADDR_W,
  parameter int DAT_W  = CB_DAT_W,
  parameter int OVF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DAT_W-1:0]  wr_dat,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_vld,
  input  bank_idx_t         wr_bank,
  input  logic              drop,
  input  logic              viol,
  input  logic              clr_max,
  output logic [1:0]        bank_we,
  output logic [ADDR_W-1:0] bank_waddr,
  output logic [DAT_W-1:0]  bank_wdat,
  output logic [ADDR_W-1:0] max_addr,
  output logic [OVF_W-1:0]  ovf_cnt
);

  logic              wr_ok;
  logic [1:0]        ovf_inc;
  logic [OVF_W+1:0]  ovf_sum;
  logic [OVF_W-1:0]  ovf_nxt;

  assign wr_ok   = wr_vld & ~drop;
  // A dropped write and a violation can land in the same cycle; count both.
  assign ovf_inc = {1'b0, wr_vld & drop} + {1'b0, viol};
  assign ovf_sum = {2'b00, ovf_cnt} + {{OVF_W{1'b0}}, ovf_inc};
  assign ovf_nxt = (ovf_sum[OVF_W+1:OVF_W] != 2'b00) ? {OVF_W{1'b1}} : ovf_sum[OVF_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_we    <= 2'b00;
      bank_waddr <= '0;
      bank_wdat  <= '0;
      max_addr   <= '0;
      ovf_cnt    <= '0;
    end else begin
      bank_we    <= wr_ok ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
      bank_waddr <= wr_addr;
      bank_wdat  <= wr_dat;
      ovf_cnt    <= ovf_nxt;
      if (clr_max) begin
        max_addr <= '0;
      end else if (wr_ok && (wr_addr > max_addr)) begin
        max_addr <= wr_addr;
      end
    end
  end

endmodule

// File: rtl/capture_bank_scheduler.sv
// Ping-pong scheduler handing filled capture banks to the phase-search engine and re-arming capture.
// Latency: writes 1 cycle; search_start 1 cycle after swap; refresh_align HOLDOFF cycles after search_start.
// Backpressure: while both banks are occupied capture is held off (no refresh_align) and writes are dropped/counted.
//
// Optional feature macro: CAPTURE_BANK_SEARCH_TIMEOUT_EN adds a search watchdog and the sticky search_timeout output.
//
// Ports:
//   alg_clk, alg_rst_n          clock, asynchronous active-low reset
//   cap_ram_dat/addr/wr_valid   capture write request
//   cap_done                    capture succeeded pulse
//   refresh_align               re-arm pulse to capture
//   bank_we/bank_waddr/wdat     registered RAM write port (bit0 = bank0)
//   search_start/bank/frame_len frame handover to search engine
//   search_done                 search engine releases its bank
//   ovf_cnt                     saturating dropped-write / violation count
//   busy                        search engine owns a bank
module capture_bank_scheduler
  import capture_bank_pkg::*;
#(
  parameter int ADDR_W  = CB_ADDR_W,
  parameter int DAT_W   = CB_DAT_W,
  parameter int OVF_W   = 16,
  parameter int HOLDOFF = 4
`ifdef CAPTURE_BANK_SEARCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic              alg_clk,
  input  logic              alg_rst_n,
  input  logic [DAT_W-1:0]  cap_ram_dat,
  input  logic [ADDR_W-1:0] cap_ram_addr,
  input  logic              cap_ram_wr_valid,
  input  logic              cap_done,
  output logic              refresh_align,
  output logic [1:0]        bank_we,
  output logic [ADDR_W-1:0] bank_waddr,
  output logic [DAT_W-1:0]  bank_wdat,
  output logic              search_start,
  output logic              search_bank,
  output logic [ADDR_W:0]   frame_len,
  input  logic              search_done,
  output logic [OVF_W-1:0]  ovf_cnt,
  output logic              busy
`ifdef CAPTURE_BANK_SEARCH_TIMEOUT_EN
  , output logic            search_timeout
`endif
);

  cb_state_t         state_q, state_d;
  bank_idx_t         wr_bank_q;
  logic [3:0]        hold_cnt_q;
  logic [ADDR_W-1:0] max_addr;
  logic              timeout_hit;
  logic              busy_rel;
  logic              busy_eff;
  logic              drop;
  logic              viol;
  logic              in_swap;

`ifdef CAPTURE_BANK_SEARCH_TIMEOUT_EN
  logic [19:0] wd_q;

  // Busy for exactly TIMEOUT_CYCLES cycles before the watchdog releases it.
  assign timeout_hit = busy && (wd_q == 20'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge alg_clk or negedge alg_rst_n) begin
    if (!alg_rst_n) begin
      wd_q           <= '0;
      search_timeout <= 1'b0;
    end else begin
      if (!busy || timeout_hit) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + 20'd1;
      end
      if (timeout_hit) begin
        search_timeout <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // A release arriving in the same cycle as cap_done counts as "not busy".
  assign busy_rel = search_done | timeout_hit;
  assign busy_eff = busy & ~busy_rel;
  assign in_swap  = (state_q == SWAP);
  assign drop     = (state_q == HOLD);
  assign viol     = cap_done & ((state_q == SWAP) | (state_q == ARM));

  always_comb begin
    state_d       = state_q;
    refresh_align = 1'b0;
    case (state_q)
      FILL: begin
        if (cap_done) begin
          state_d = busy_eff ? HOLD : SWAP;
        end
      end
      HOLD: begin
        if (!busy_eff) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        state_d = ARM;
      end
      ARM: begin
        if (hold_cnt_q == 4'd0) begin
          refresh_align = 1'b1;
          state_d       = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge alg_clk or negedge alg_rst_n) begin
    if (!alg_rst_n) begin
      state_q      <= FILL;
      wr_bank_q    <= 1'b0;
      hold_cnt_q   <= 4'd0;
      search_start <= 1'b0;
      search_bank  <= 1'b0;
      frame_len    <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      search_start <= in_swap;
      if (in_swap) begin
        search_bank <= wr_bank_q;
        wr_bank_q   <= ~wr_bank_q;
        frame_len   <= {1'b0, max_addr} + (ADDR_W+1)'(1);
        hold_cnt_q  <= 4'(HOLDOFF);
        busy        <= 1'b1;
      end else begin
        if (busy_rel) begin
          busy <= 1'b0;
        end
        if ((state_q == ARM) && (hold_cnt_q != 4'd0)) begin
          hold_cnt_q <= hold_cnt_q - 4'd1;
        end
      end
    end
  end

  capture_bank_wr_mux #(
    .ADDR_W (ADDR_W),
    .DAT_W  (DAT_W),
    .OVF_W  (OVF_W)
  ) u_wr_mux (
    .clk        (alg_clk),
    .rst_n      (alg_rst_n),
    .wr_dat     (cap_ram_dat),
    .wr_addr    (cap_ram_addr),
    .wr_vld     (cap_ram_wr_valid),
    .wr_bank    (wr_bank_q),
    .drop       (drop),
    .viol       (viol),
    .clr_max    (in_swap),
    .bank_we    (bank_we),
    .bank_waddr (bank_waddr),
    .bank_wdat  (bank_wdat),
    .max_addr   (max_addr),
    .ovf_cnt    (ovf_cnt)
  );

endmodule

// File: tb/tb_capture_bank_scheduler.sv
// Directed bench for capture_bank_scheduler (default build, HOLDOFF = 4).
// Latency: inputs driven 1 time unit after the rising edge, outputs checked before the next edge.
// Backpressure: exercises HOLD with dropped writes, simultaneous cap_done/search_done and reset in ARM.
module tb_capture_bank_scheduler;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int OW = 16;
  localparam int HO = 4;

  logic          alg_clk          = 1'b0;
  logic          alg_rst_n        = 1'b0;
  logic [DW-1:0] cap_ram_dat      = '0;
  logic [AW-1:0] cap_ram_addr     = '0;
  logic          cap_ram_wr_valid = 1'b0;
  logic          cap_done         = 1'b0;
  logic          search_done      = 1'b0;
  logic          refresh_align;
  logic [1:0]    bank_we;
  logic [AW-1:0] bank_waddr;
  logic [DW-1:0] bank_wdat;
  logic          search_start;
  logic          search_bank;
  logic [AW:0]   frame_len;
  logic [OW-1:0] ovf_cnt;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  capture_bank_scheduler #(
    .ADDR_W  (AW),
    .DAT_W   (DW),
    .OVF_W   (OW),
    .HOLDOFF (HO)
  ) dut (
    .alg_clk          (alg_clk),
    .alg_rst_n        (alg_rst_n),
    .cap_ram_dat      (cap_ram_dat),
    .cap_ram_addr     (cap_ram_addr),
    .cap_ram_wr_valid (cap_ram_wr_valid),
    .cap_done         (cap_done),
    .refresh_align    (refresh_align),
    .bank_we          (bank_we),
    .bank_waddr       (bank_waddr),
    .bank_wdat        (bank_wdat),
    .search_start     (search_start),
    .search_bank      (search_bank),
    .frame_len        (frame_len),
    .search_done      (search_done),
    .ovf_cnt          (ovf_cnt),
    .busy             (busy)
  );

  always #5 alg_clk = ~alg_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge alg_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_refresh"}, 32'(refresh_align), 32'd0);
    chk({tag, "_we"},      32'(bank_we),       32'd0);
    chk({tag, "_waddr"},   32'(bank_waddr),    32'd0);
    chk({tag, "_wdat"},    32'(bank_wdat),     32'd0);
    chk({tag, "_start"},   32'(search_start),  32'd0);
    chk({tag, "_sbank"},   32'(search_bank),   32'd0);
    chk({tag, "_flen"},    32'(frame_len),     32'd0);
    chk({tag, "_ovf"},     32'(ovf_cnt),       32'd0);
    chk({tag, "_busy"},    32'(busy),          32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk_all_zero("rst");
    step();
    step();
    alg_rst_n = 1'b1;

    // Frame 1: addr 0..99 into bank 0
    for (int a = 0; a < 100; a++) begin
      cap_ram_wr_valid = 1'b1;
      cap_ram_addr     = AW'(a);
      cap_ram_dat      = DW'(a) ^ 16'hA5A5;
      if (a == 0) chk("f1_we_before_edge", 32'(bank_we), 32'd0);
      step();
      chk("f1_we",    32'(bank_we),    32'd1);
      chk("f1_waddr", 32'(bank_waddr), 32'(a));
      chk("f1_wdat",  32'(bank_wdat),  32'(a ^ 16'hA5A5));
    end
    cap_ram_wr_valid = 1'b0;
    cap_done         = 1'b1;
    step();                               // SWAP
    cap_done = 1'b0;
    chk("f1_swap_start", 32'(search_start), 32'd0);
    chk("f1_swap_busy",  32'(busy),         32'd0);
    chk("f1_swap_we",    32'(bank_we),      32'd0);
    step();                               // first ARM cycle
    chk("f1_start", 32'(search_start),  32'd1);
    chk("f1_sbank", 32'(search_bank),   32'd0);
    chk("f1_flen",  32'(frame_len),     32'd100);
    chk("f1_busy",  32'(busy),          32'd1);
    chk("f1_ref0",  32'(refresh_align), 32'd0);
    for (int i = 1; i <= HO; i++) begin
      step();
      chk("f1_refresh", 32'(refresh_align), 32'(i == HO));
      chk("f1_start_off", 32'(search_start), 32'd0);
    end
    step();                               // back in FILL
    chk("f1_ref_after", 32'(refresh_align), 32'd0);

    // Frame 2: addr 0..119 into bank 1, search still busy -> HOLD
    for (int a = 0; a < 120; a++) begin
      cap_ram_wr_valid = 1'b1;
      cap_ram_addr     = AW'(a);
      cap_ram_dat      = DW'(a) + 16'h1000;
      step();
      chk("f2_we",    32'(bank_we),    32'd2);
      chk("f2_waddr", 32'(bank_waddr), 32'(a));
    end
    cap_ram_wr_valid = 1'b0;
    cap_done         = 1'b1;
    step();                               // HOLD
    cap_done = 1'b0;
    chk("f2_hold_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cap_ram_wr_valid = 1'b1;
      cap_ram_addr     = AW'(200 + k);
      step();
      chk("f2_drop_we",  32'(bank_we),       32'd0);
      chk("f2_hold_ref", 32'(refresh_align), 32'd0);
    end
    cap_ram_wr_valid = 1'b0;
    chk("f2_ovf5", 32'(ovf_cnt), 32'd5);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("f2_hold_ref_idle",   32'(refresh_align), 32'd0);
      chk("f2_hold_start_idle", 32'(search_start),  32'd0);
    end
    search_done = 1'b1;
    step();                               // SWAP
    search_done = 1'b0;
    chk("f2_swap_busy", 32'(busy), 32'd0);
    step();
    chk("f2_start", 32'(search_start), 32'd1);
    chk("f2_sbank", 32'(search_bank),  32'd1);
    chk("f2_flen",  32'(frame_len),    32'd120);
    chk("f2_busy",  32'(busy),         32'd1);
    for (int i = 1; i <= HO; i++) begin
      step();
      chk("f2_refresh", 32'(refresh_align), 32'(i == HO));
    end
    step();                               // FILL, wr_bank back to 0

    // Frame 3: cap_done and search_done together -> straight to SWAP
    for (int a = 0; a < 10; a++) begin
      cap_ram_wr_valid = 1'b1;
      cap_ram_addr     = AW'(a);
      step();
      chk("f3_we", 32'(bank_we), 32'd1);
    end
    cap_ram_wr_valid = 1'b0;
    cap_done         = 1'b1;
    search_done      = 1'b1;
    step();
    cap_done    = 1'b0;
    search_done = 1'b0;
    chk("f3_swap_busy", 32'(busy),          32'd0);
    chk("f3_swap_ref",  32'(refresh_align), 32'd0);
    step();
    chk("f3_start", 32'(search_start), 32'd1);
    chk("f3_sbank", 32'(search_bank),  32'd0);
    chk("f3_flen",  32'(frame_len),    32'd10);
    chk("f3_ovf",   32'(ovf_cnt),      32'd5);

    // cap_done in ARM is a violation, counted once
    cap_done = 1'b1;
    step();
    cap_done = 1'b0;
    chk("f3_viol_ovf", 32'(ovf_cnt),       32'd6);
    chk("f3_viol_ref", 32'(refresh_align), 32'd0);

    // Asynchronous reset mid-ARM
    #2;
    alg_rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    step();
    step();
    alg_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_ref",   32'(refresh_align), 32'd0);
      chk("post_rst_start", 32'(search_start),  32'd0);
      chk("post_rst_busy",  32'(busy),          32'd0);
    end
    cap_ram_wr_valid = 1'b1;
    cap_ram_addr     = AW'(7);
    step();
    chk("post_rst_we_bank0", 32'(bank_we),    32'd1);
    chk("post_rst_waddr",    32'(bank_waddr), 32'd7);
    cap_ram_wr_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
